// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits are served in the request cycle from internal tag/data registers. A miss
// writes back a dirty victim line, refills the line from the BRAM port, and then
// lets the still-held request complete as an ordinary hit.
`timescale 1ns/1ps
module dcache_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [3:0]            cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_BITS = ADDR_WIDTH - OFFSET_BITS;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORDS     = 1 << OFFSET_BITS;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WRITEBACK   = 2'd1;
    localparam logic [1:0] REFILL      = 2'd2;
    localparam logic [1:0] REFILL_LAST = 2'd3;

    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;
    localparam logic [OFFSET_BITS-1:0] ONE       = {{(OFFSET_BITS-1){1'b0}}, 1'b1};

    logic [1:0]             state;
    logic [OFFSET_BITS-1:0] counter;
    logic [LINE_BITS-1:0]   miss_line;

    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;
    logic [TAG_BITS-1:0]    tags [LINES];
    logic [31:0]            data [LINES][WORDS];

    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_index;
    logic [OFFSET_BITS-1:0] req_offset;
    logic [TAG_BITS-1:0]    miss_tag;
    logic [INDEX_BITS-1:0]  miss_index;
    logic                   hit;
    logic                   store_hit;
    logic                   miss_start;

    assign req_tag    = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_index  = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_offset = cpu_addr[OFFSET_BITS-1:0];

    // The miss only needs tag and index; the word offset is walked by the counter.
    assign miss_tag   = miss_line[LINE_BITS-1 -: TAG_BITS];
    assign miss_index = miss_line[INDEX_BITS-1:0];

    assign hit        = cpu_req & valid[req_index] & (tags[req_index] == req_tag);
    assign cpu_ready  = (state == IDLE) & hit;
    assign cpu_rdata  = cpu_ready ? data[req_index][req_offset] : 32'd0;
    assign store_hit  = cpu_ready & (|cpu_we);
    assign miss_start = (state == IDLE) & cpu_req & ~hit;

    // BRAM port drive: victim words out during WRITEBACK, line reads during REFILL.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 4'h0;
        mem_addr = '0;
        mem_din  = 32'd0;
        case (state)
            WRITEBACK: begin
                mem_en   = 1'b1;
                mem_we   = 4'hF;
                mem_addr = {tags[miss_index], miss_index, counter};
                mem_din  = data[miss_index][counter];
            end
            REFILL: begin
                mem_en   = 1'b1;
                mem_addr = {miss_tag, miss_index, counter};
            end
            default: ;
        endcase
    end

    // Control state: FSM, word counter, latched miss line and per-line valid/dirty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            miss_line <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        miss_line <= cpu_addr[ADDR_WIDTH-1:OFFSET_BITS];
                        counter   <= '0;
                        state     <= (valid[req_index] & dirty[req_index]) ? WRITEBACK : REFILL;
                    end else if (store_hit) begin
                        dirty[req_index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    counter <= counter + ONE;
                    if (counter == LAST_WORD) begin
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    counter <= counter + ONE;
                    if (counter == LAST_WORD) begin
                        state <= REFILL_LAST;
                    end
                end
                REFILL_LAST: begin
                    valid[miss_index] <= 1'b1;
                    dirty[miss_index] <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage: store-hit byte merges, and refill capture one cycle behind each read.
    always_ff @(posedge clk) begin
        if (store_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (cpu_we[i]) begin
                    data[req_index][req_offset][i*8 +: 8] <= cpu_wdata[i*8 +: 8];
                end
            end
        end
        if (state == REFILL && counter != '0) begin
            data[miss_index][counter - ONE] <= mem_dout;
        end
        if (state == REFILL_LAST) begin
            data[miss_index][LAST_WORD] <= mem_dout;
            tags[miss_index]            <= miss_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed table, multi-cycle corner sequences and randomized
// accesses against an architectural memory model with a line-presence model.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    dcache_ctrl #(.ADDR_WIDTH(11), .INDEX_BITS(4), .OFFSET_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to measure throughput.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(int i);
        return (i == 'h011) ? 32'h1122_3344 : (32'h5A00_0000 | 32'(i));
    endfunction

    // Byte-write BRAM with one-cycle registered read.
    logic [31:0] bram [2048];
    logic        bram_init;
    always @(posedge clk) begin
        if (bram_init) begin
            for (int i = 0; i < 2048; i++) bram[i] <= init_val(i);
        end else if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) bram[mem_addr][i*8 +: 8] <= mem_din[i*8 +: 8];
            mem_dout <= bram[mem_addr];
        end
    end

    // Reference: architectural memory contents plus which line sits at each index.
    logic [31:0] golden [2048];
    bit          mv [16];
    bit          md [16];
    logic [4:0]  mt [16];

    logic [63:0] rec [64];

    function automatic logic [63:0] pack(logic en, logic [3:0] we, logic [10:0] a, logic [31:0] d);
        return {16'd0, en, we, a, d};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    // Drive one request from a falling edge and hold it until cpu_ready.
    task automatic apply_stimulus(input logic [3:0] we, input logic [10:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output int lat);
        int c;
        bit done;
        c = 0; done = 1'b0; lat = -1; rdata = 32'd0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        while (!done) begin
            rec[c] = pack(mem_en, mem_we, mem_addr, mem_din);
            if (cpu_ready) begin
                lat = c; rdata = cpu_rdata; done = 1'b1;
            end else if (c == 40) begin
                check_output("ready_timeout", 64'(cpu_ready), 64'd1);
                done = 1'b1;
            end else begin
                @(negedge clk); #1; c++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 4'h0;
    endtask

    // One access: predict from the model, apply, check BRAM traffic, update the model.
    task automatic run_access(input logic [3:0] we, input logic [10:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int lat,
                              output int exp_lat, output logic [31:0] exp_rdata);
        logic [3:0]  idx;
        logic [4:0]  tag, vt;
        logic [10:0] wa;
        logic [63:0] ex, mask;
        int base;
        idx = addr[5:2]; tag = addr[10:6]; vt = mt[idx];
        if (mv[idx] && mt[idx] == tag) exp_lat = 0;
        else if (mv[idx] && md[idx])   exp_lat = 10;
        else                           exp_lat = 6;
        base = (exp_lat == 10) ? 4 : 0;
        exp_rdata = golden[addr];
        apply_stimulus(we, addr, wdata, rdata, lat);
        if (lat == exp_lat) begin
            for (int c = 0; c <= lat; c++) begin
                if (c == 0 || c == lat) begin
                    ex = 64'd0; mask = pack(1'b1, 4'hF, 11'h0, 32'h0);
                end else if (c <= base) begin
                    wa = {vt, idx, 2'(c - 1)};
                    ex = pack(1'b1, 4'hF, wa, golden[wa]); mask = '1;
                end else if (c <= base + 4) begin
                    ex = pack(1'b1, 4'h0, {tag, idx, 2'(c - base - 1)}, 32'h0);
                    mask = pack(1'b1, 4'hF, 11'h7FF, 32'h0);
                end else begin
                    ex = 64'd0; mask = pack(1'b1, 4'h0, 11'h0, 32'h0);
                end
                check_output($sformatf("mem_c%0d_a%03h", c, addr), rec[c] & mask, ex & mask);
            end
        end
        if (exp_lat != 0) begin
            mv[idx] = 1'b1; mt[idx] = tag; md[idx] = 1'b0;
        end
        if (we != 4'h0) begin
            md[idx] = 1'b1;
            for (int i = 0; i < 4; i++)
                if (we[i]) golden[addr][i*8 +: 8] = wdata[i*8 +: 8];
        end
    endtask

    typedef struct {
        logic [3:0]  we;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rdata, exp_rdata;
        logic [10:0] bb_addr [8];
        logic [3:0]  we;
        logic [10:0] addr;
        int lat, exp_lat, t0;

        vecs[0] = '{4'h0, 11'h010, 32'h0,         32'h5A00_0010, 6};
        vecs[1] = '{4'h0, 11'h013, 32'h0,         32'h5A00_0013, 0};
        vecs[2] = '{4'h2, 11'h011, 32'h0000_AB00, 32'h0,         0};
        vecs[3] = '{4'h0, 11'h011, 32'h0,         32'h1122_AB44, 0};
        vecs[4] = '{4'h0, 11'h050, 32'h0,         32'h5A00_0050, 10};
        vecs[5] = '{4'hF, 11'h7FF, 32'hDEAD_BEEF, 32'h0,         6};
        vecs[6] = '{4'h0, 11'h7FF, 32'h0,         32'hDEAD_BEEF, 0};
        vecs[7] = '{4'h0, 11'h3FF, 32'h0,         32'h5A00_03FF, 10};

        rst = 1'b1; bram_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 11'h0; cpu_wdata = 32'h0;
        for (int i = 0; i < 2048; i++) golden[i] = init_val(i);
        model_reset();
        @(posedge clk); #1; bram_init = 1'b0;

        // Outputs while held in reset.
        @(negedge clk); #1;
        check_output("rst_ready", 64'(cpu_ready), 64'd0);
        check_output("rst_rdata", 64'(cpu_rdata), 64'd0);
        check_output("rst_en",    64'(mem_en),    64'd0);
        check_output("rst_we",    64'(mem_we),    64'd0);
        check_output("rst_addr",  64'(mem_addr),  64'd0);
        check_output("rst_din",   64'(mem_din),   64'd0);
        @(negedge clk); rst = 1'b0;

        // Reset during the second REFILL cycle of a cold load.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 11'h010;
        @(negedge clk); #1;
        check_output("mr_c1", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 4'h0, 11'h010}));
        @(negedge clk); #1;
        check_output("mr_c2", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 4'h0, 11'h011}));
        rst = 1'b1; #1;
        check_output("mr_ready", 64'(cpu_ready), 64'd0);
        check_output("mr_rdata", 64'(cpu_rdata), 64'd0);
        check_output("mr_en",    64'(mem_en),    64'd0);
        check_output("mr_we",    64'(mem_we),    64'd0);
        check_output("mr_addr",  64'(mem_addr),  64'd0);
        check_output("mr_din",   64'(mem_din),   64'd0);
        @(negedge clk);
        cpu_req = 1'b0; rst = 1'b0;
        model_reset();

        // Directed table: cold load, hit, byte store, dirty eviction, store miss.
        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, lat, exp_lat, exp_rdata);
            check_output($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            if (vecs[i].we == 4'h0)
                check_output($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
        end
        check_output("wb_011", 64'(bram[11'h011]), 64'h1122_AB44);
        check_output("wb_7ff", 64'(bram[11'h7FF]), 64'hDEAD_BEEF);

        // Eight back-to-back hits to resident lines, one per cycle.
        bb_addr = '{11'h050, 11'h3FC, 11'h051, 11'h3FD, 11'h052, 11'h3FE, 11'h053, 11'h3FF};
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            we = (i % 2 == 1) ? 4'h5 : 4'h0;
            run_access(we, bb_addr[i], 32'hC0FF_EE00 + 32'(i), rdata, lat, exp_lat, exp_rdata);
            check_output($sformatf("b2b%0d_lat", i), 64'(lat), 64'd0);
            if (we == 4'h0) check_output($sformatf("b2b%0d_rdata", i), 64'(rdata), 64'(exp_rdata));
        end
        check_output("b2b_cycles", 64'(cyc - t0), 64'd8);

        // Randomized accesses over a few tags so hits, clean and dirty misses all occur.
        for (int i = 0; i < 300; i++) begin
            addr = {5'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            we   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_access(we, addr, $urandom, rdata, lat, exp_lat, exp_rdata);
            check_output($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat));
            if (we == 4'h0) check_output($sformatf("rnd%0d_rdata", i), 64'(rdata), 64'(exp_rdata));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
